gat_load_scheduler: RTL and testbench
=====================================

Name: gat_load_scheduler

Overview:
- Per-layer sequencer for the GAT accelerator front end: drives the valid/ready handshakes of the weight (W), attention-vector (A) and feature (H) loaders in fixed order, then launches and waits for the compute stage.
- Loops over NUM_LAYERS layers and clears the sticky loader ready flags between layers.
- Sits between the top-level host start/done interface and the loader/compute blocks.

Parameters:
- NUM_LAYERS, 2, number of layers processed per start.
- LAYER_W, 1, width of the layer index; must satisfy 2^LAYER_W >= NUM_LAYERS.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state; used only with SCHED_TIMEOUT_EN.
- TIMEOUT_W, 16, width of the watchdog counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- start_i  input  1  one-cycle start request from host.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- done_o  output  1  one-cycle pulse when all layers are complete.
- layer_idx_o  output  LAYER_W  current layer index.
- w_valid_o  output  1  load request to the weight loader.
- w_ready_i  input  1  sticky load-complete from the weight loader.
- a_valid_o  output  1  load request to the attention-vector loader.
- a_ready_i  input  1  sticky load-complete from the attention-vector loader.
- h_valid_o  output  1  load request to the feature loader.
- h_ready_i  input  1  sticky load-complete from the feature loader.
- loader_clr_o  output  1  one-cycle synchronous clear to all loaders.
- compute_start_o  output  1  one-cycle compute launch pulse.
- compute_done_i  input  1  compute-complete pulse or level.
- error_o  output  1  watchdog error flag; sticky.

Behaviour:
- States: IDLE, LOAD_W, LOAD_A, LOAD_H, COMPUTE, NEXT, DONE (plus ERROR with the optional feature). State is encoded in registers.
- All outputs are registered Moore outputs decoded from the state register; pulses are asserted for exactly one cycle.
- Reset values: state=IDLE, layer_idx_o=0, all outputs 0. Reset asserted mid-operation returns to IDLE in the next cycle and drops all outputs regardless of state; no pulses are emitted.
- IDLE -> LOAD_W when start_i=1. w_valid_o rises the cycle after start_i is sampled. start_i is ignored in every other state.
- LOAD_W: w_valid_o=1 and is held until w_ready_i is sampled high, then -> LOAD_A. The ready is sampled every cycle, including the first cycle in the state.
- LOAD_A: a_valid_o=1 until a_ready_i, then -> LOAD_H.
- LOAD_H: h_valid_o=1 until h_ready_i, then -> COMPUTE.
- Exactly one valid is high at a time; all valids drop the cycle after the matching ready is seen.
- COMPUTE: compute_start_o pulses on the first cycle in the state only. Waits for compute_done_i; if compute_done_i is high on the entry cycle, it is accepted.
- compute_done_i and all *_ready_i inputs are ignored outside their own wait state.
- NEXT: one cycle; loader_clr_o=1.
  - If layer_idx_o == NUM_LAYERS-1: -> DONE, and layer_idx_o resets to 0.
  - Otherwise: layer_idx_o increments and -> LOAD_W.
- DONE: one cycle; done_o=1; -> IDLE. A start_i arriving in the DONE cycle is ignored.
- Back-to-back operation: start_i in the cycle after DONE (FSM in IDLE) is accepted normally.
- Latency: minimum start-to-done is 7 + 6*(NUM_LAYERS-1) cycles with all readies and done already high. For NUM_LAYERS=2 this is 13 cycles from the start_i sample edge to the done_o rise.
- layer_idx_o changes only on the NEXT->LOAD_W or NEXT->DONE transition; it never exceeds NUM_LAYERS-1.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Enabled:
  - Counter clears on entry to each of LOAD_W, LOAD_A, LOAD_H and COMPUTE, and increments every cycle spent waiting in that state.
  - When the count reaches TIMEOUT_CYCLES without the awaited ready/done, the FSM enters ERROR: all valids drop, error_o=1 (sticky), busy_o=1.
  - ERROR exits only through rst_n; start_i is ignored.
- Disabled: no counter logic; error_o tied to 0; waits are unbounded.

Test Plan:
- Basic flow: NUM_LAYERS=2, readies return 5 cycles after each valid, compute_done 10 cycles after start -> order per layer is W, A, H, compute; one loader_clr_o between layers; layer_idx_o goes 0, 1, 0; a single done_o pulse; busy_o drops with done.
- Fast path: all readies and compute_done tied high -> done_o rises 13 cycles after start_i; exactly 2 compute_start_o pulses; each valid is high for 1 cycle.
- Ignored inputs: start_i pulsed during LOAD_A and during DONE; a_ready_i asserted during LOAD_W -> no restart, no state skip, a_valid_o still asserted later until a_ready_i is sampled in LOAD_A.
- Reset mid-operation: rst_n low for 1 cycle during COMPUTE of layer 1 -> next cycle state=IDLE, layer_idx_o=0, all outputs 0; a fresh start completes normally.
- Back-to-back runs: start_i the cycle after done_o -> second run completes identically, with 2 done_o pulses total.
- Watchdog (SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20): h_ready_i held low -> error_o rises 20 cycles after entering LOAD_H, h_valid_o drops; start_i is ignored until reset.

Source files
------------

// File: rtl/gat_load_scheduler.sv
// gat_load_scheduler: per-layer W/A/H load and compute sequencer for the GAT front end.
// Optional watchdog (ERROR state, sticky error_o) is built when SCHED_TIMEOUT_EN is defined.
module gat_load_scheduler #(
  parameter int unsigned NUM_LAYERS     = 2,
  parameter int unsigned LAYER_W        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               w_valid_o,
  input  logic               w_ready_i,
  output logic               a_valid_o,
  input  logic               a_ready_i,
  output logic               h_valid_o,
  input  logic               h_ready_i,
  output logic               loader_clr_o,
  output logic               compute_start_o,
  input  logic               compute_done_i,
  output logic               error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_A, S_LOAD_H, S_COMPUTE, S_NEXT, S_DONE
`ifdef SCHED_TIMEOUT_EN
    , S_ERROR
`endif
  } state_e;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_e              state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic                first_q;
  logic                cdone_q, cdone_d;
  logic                w_valid_q, a_valid_q, h_valid_q, busy_q, done_q, cstart_q, clr_q;
  logic                w_valid_d, a_valid_d, h_valid_d, busy_d, done_d, cstart_d, clr_d;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 wait_st;
  logic                 err_q, err_d;

  assign wait_st = state_q inside {S_LOAD_W, S_LOAD_A, S_LOAD_H, S_COMPUTE};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      first_q <= 1'b0;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      first_q <= (state_d != state_q);
      cdone_q <= cdone_d;
    end
  end

  // COMPUTE always spends its first cycle issuing the launch; a done seen then is held in cdone_q.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cdone_d = 1'b0;
    case (state_q)
      S_IDLE:   if (start_i)   state_d = S_LOAD_W;
      S_LOAD_W: if (w_ready_i) state_d = S_LOAD_A;
      S_LOAD_A: if (a_ready_i) state_d = S_LOAD_H;
      S_LOAD_H: if (h_ready_i) state_d = S_COMPUTE;
      S_COMPUTE: begin
        if (first_q)                             cdone_d = compute_done_i;
        else if (cdone_q || compute_done_i)      state_d = S_NEXT;
      end
      S_NEXT: begin
        if (layer_q == LAST_LAYER) begin
          layer_d = '0;
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + 1'b1;
          state_d = S_LOAD_W;
        end
      end
      S_DONE:   state_d = S_IDLE;
`ifdef SCHED_TIMEOUT_EN
      S_ERROR:  state_d = S_ERROR;
`endif
      default:  state_d = S_IDLE;
    endcase
`ifdef SCHED_TIMEOUT_EN
    if (wait_st && (state_d == state_q) && !cdone_d && (cnt_q == CNT_LAST))
      state_d = S_ERROR;
`endif
  end

`ifdef SCHED_TIMEOUT_EN
  always_comb begin
    cnt_d = ((state_d != state_q) || !wait_st) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic [TIMEOUT_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
`endif

  // Clear and error track state_d so loaders drop sticky readies before LOAD_W samples them.
  always_comb begin
    w_valid_d = (state_q == S_LOAD_W);
    a_valid_d = (state_q == S_LOAD_A);
    h_valid_d = (state_q == S_LOAD_H);
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_DONE);
    cstart_d  = (state_q == S_COMPUTE) && first_q;
    clr_d     = (state_d == S_NEXT);
`ifdef SCHED_TIMEOUT_EN
    err_d     = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid_q <= 1'b0;
      a_valid_q <= 1'b0;
      h_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cstart_q  <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      w_valid_q <= w_valid_d;
      a_valid_q <= a_valid_d;
      h_valid_q <= h_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cstart_q  <= cstart_d;
      clr_q     <= clr_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign w_valid_o       = w_valid_q;
  assign a_valid_o       = a_valid_q;
  assign h_valid_o       = h_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign compute_start_o = cstart_q;
  assign loader_clr_o    = clr_q;
  assign layer_idx_o     = layer_q;

endmodule

// File: tb/tb_gat_load_scheduler.sv
// Directed bench for gat_load_scheduler: sticky loader and compute models advanced once per clock.
module tb_gat_load_scheduler;

  localparam int LAT  = 5;
  localparam int CLAT = 10;

  logic       clk, rst_n, start_i;
  logic       busy_o, done_o;
  logic [0:0] layer_idx_o;
  logic       w_valid_o, w_ready_i, a_valid_o, a_ready_i, h_valid_o, h_ready_i;
  logic       loader_clr_o, compute_start_o, compute_done_i, error_o;
  logic [8:0] outs;

  int    checks = 0;
  int    errors = 0;
  int    mode;  // 0 manual, 1 everything tied high, 2 reactive loader/compute models
  int    wcnt, acnt, hcnt, ccnt;
  int    w_hi, a_hi, h_hi, cs_n, done_n, clr_n;
  string seq;

  gat_load_scheduler #(
    .NUM_LAYERS    (2),
    .LAYER_W       (1),
    .TIMEOUT_CYCLES(20),
    .TIMEOUT_W     (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .layer_idx_o    (layer_idx_o),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready_i),
    .a_valid_o      (a_valid_o),
    .a_ready_i      (a_ready_i),
    .h_valid_o      (h_valid_o),
    .h_ready_i      (h_ready_i),
    .loader_clr_o   (loader_clr_o),
    .compute_start_o(compute_start_o),
    .compute_done_i (compute_done_i),
    .error_o        (error_o)
  );

  assign outs = {w_valid_o, a_valid_o, h_valid_o, busy_o, done_o,
                 loader_clr_o, compute_start_o, error_o, layer_idx_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic pw, pa, ph, pc, pclr;
    pw = w_valid_o; pa = a_valid_o; ph = h_valid_o; pc = compute_start_o; pclr = loader_clr_o;
    @(posedge clk);
    #1;
    if (mode == 1) begin
      w_ready_i = 1'b1; a_ready_i = 1'b1; h_ready_i = 1'b1; compute_done_i = 1'b1;
    end else if (mode == 2) begin
      if (pclr) begin w_ready_i = 1'b0; wcnt = 0; end
      else if (pw && !w_ready_i) begin wcnt++; if (wcnt == LAT) w_ready_i = 1'b1; end
      if (pclr) begin a_ready_i = 1'b0; acnt = 0; end
      else if (pa && !a_ready_i) begin acnt++; if (acnt == LAT) a_ready_i = 1'b1; end
      if (pclr) begin h_ready_i = 1'b0; hcnt = 0; end
      else if (ph && !h_ready_i) begin hcnt++; if (hcnt == LAT) h_ready_i = 1'b1; end
      if (pc) ccnt = CLAT;
      else if (ccnt != 0) ccnt--;
      compute_done_i = (ccnt == 1);
    end
    if (w_valid_o && !pw) seq = {seq, "W"};
    if (a_valid_o && !pa) seq = {seq, "A"};
    if (h_valid_o && !ph) seq = {seq, "H"};
    if (compute_start_o) begin
      if (layer_idx_o == 1'b1) seq = {seq, "C1"};
      else                     seq = {seq, "C0"};
      cs_n++;
    end
    if (loader_clr_o) begin seq = {seq, "X"}; clr_n++; end
    if (done_o) begin seq = {seq, "D"}; done_n++; end
    w_hi += int'(w_valid_o); a_hi += int'(a_valid_o); h_hi += int'(h_valid_o);
  endtask

  task automatic clear_trace();
    seq = ""; w_hi = 0; a_hi = 0; h_hi = 0; cs_n = 0; done_n = 0; clr_n = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0;
    w_ready_i = 1'b0; a_ready_i = 1'b0; h_ready_i = 1'b0; compute_done_i = 1'b0;
    wcnt = 0; acnt = 0; hcnt = 0; ccnt = 0;
    tick(); tick();
    rst_n = 1'b1;
    clear_trace();
  endtask

  task automatic run_until_done(output int n);
    n = 0;
    while (!done_o && n < 200) begin tick(); n++; end
  endtask

  task automatic test_reset();
    mode = 0;
    rst_n = 1'b0; start_i = 1'b0;
    w_ready_i = 1'b0; a_ready_i = 1'b0; h_ready_i = 1'b0; compute_done_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, 9'b0); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL idle_outs: got %b expected %b", outs, 9'b0); end
  endtask

  task automatic test_fast_path();
    int n;
    mode = 1;
    do_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    run_until_done(n);
    checks++;
    if (n !== 13) begin errors++; $display("FAIL fast_latency: got %0d expected %0d", n, 13); end
    checks++;
    if (cs_n !== 2) begin errors++; $display("FAIL fast_cstart_count: got %0d expected %0d", cs_n, 2); end
    checks++;
    if (w_hi !== 2 || a_hi !== 2 || h_hi !== 2) begin
      errors++; $display("FAIL fast_valid_cycles: got w%0d a%0d h%0d expected 2 each", w_hi, a_hi, h_hi);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || done_n !== 1) begin
      errors++; $display("FAIL fast_done_pulse: got done=%b count=%0d expected 0 and 1", done_o, done_n);
    end
  endtask

  task automatic test_basic_flow();
    int n;
    mode = 2;
    do_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    run_until_done(n);
    checks++;
    if (n !== 69) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, 69); end
    checks++;
    if (seq != "WAHC0XWAHC1XD") begin errors++; $display("FAIL basic_order: got %s expected %s", seq, "WAHC0XWAHC1XD"); end
    checks++;
    if (layer_idx_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_done_cycle: got layer=%0d busy=%b expected 0 and 1", layer_idx_o, busy_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL basic_busy_drop: got busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    checks++;
    if (done_n !== 1 || clr_n !== 2) begin
      errors++; $display("FAIL basic_pulse_counts: got done=%0d clr=%0d expected 1 and 2", done_n, clr_n);
    end
  endtask

  task automatic test_ignored_inputs();
    mode = 0;
    do_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    a_ready_i = 1'b1; tick();
    checks++;
    if (w_valid_o !== 1'b1 || a_valid_o !== 1'b0) begin
      errors++; $display("FAIL ign_w_first: got w=%b a=%b expected 1 0", w_valid_o, a_valid_o);
    end
    a_ready_i = 1'b0; tick();
    checks++;
    if (w_valid_o !== 1'b1 || a_valid_o !== 1'b0) begin
      errors++; $display("FAIL ign_no_skip: got w=%b a=%b expected 1 0", w_valid_o, a_valid_o);
    end
    w_ready_i = 1'b1; tick(); w_ready_i = 1'b0; tick();
    checks++;
    if (w_valid_o !== 1'b0 || a_valid_o !== 1'b1) begin
      errors++; $display("FAIL ign_a_valid: got w=%b a=%b expected 0 1", w_valid_o, a_valid_o);
    end
    start_i = 1'b1; tick(); start_i = 1'b0; tick(); tick();
    checks++;
    if ({w_valid_o, a_valid_o, h_valid_o} !== 3'b010) begin
      errors++; $display("FAIL ign_start_in_a: got %b expected %b", {w_valid_o, a_valid_o, h_valid_o}, 3'b010);
    end
    a_ready_i = 1'b1; tick(); a_ready_i = 1'b0; tick();
    checks++;
    if ({w_valid_o, a_valid_o, h_valid_o} !== 3'b001) begin
      errors++; $display("FAIL ign_h_valid: got %b expected %b", {w_valid_o, a_valid_o, h_valid_o}, 3'b001);
    end
    w_ready_i = 1'b1; a_ready_i = 1'b1; h_ready_i = 1'b1; compute_done_i = 1'b1;
    repeat (10) tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || layer_idx_o !== 1'b0) begin
      errors++; $display("FAIL ign_done: got done=%b layer=%0d expected 1 0", done_o, layer_idx_o);
    end
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || w_valid_o !== 1'b0) begin
      errors++; $display("FAIL ign_start_in_done: got busy=%b w=%b expected 0 0", busy_o, w_valid_o);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    mode = 1;
    do_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (9) tick();
    checks++;
    if (layer_idx_o !== 1'b1) begin errors++; $display("FAIL midrst_layer1: got %0d expected %0d", layer_idx_o, 1); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL midrst_outs: got %b expected %b", outs, 9'b0); end
    tick();
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL midrst_quiet: got %b expected %b", outs, 9'b0); end
    start_i = 1'b1; tick(); start_i = 1'b0;
    run_until_done(n);
    checks++;
    if (n !== 13) begin errors++; $display("FAIL midrst_restart: got %0d expected %0d", n, 13); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    mode = 1;
    do_reset();
    start_i = 1'b1; tick(); start_i = 1'b0;
    run_until_done(n1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    run_until_done(n2);
    checks++;
    if (n1 !== 13 || n2 !== 13) begin errors++; $display("FAIL b2b_latency: got %0d,%0d expected 13,13", n1, n2); end
    tick();
    checks++;
    if (done_n !== 2 || cs_n !== 4) begin
      errors++; $display("FAIL b2b_counts: got done=%0d cstart=%0d expected 2 and 4", done_n, cs_n);
    end
  endtask

  task automatic test_watchdog();
    int n;
    mode = 0;
    do_reset();
    w_ready_i = 1'b1; a_ready_i = 1'b1; h_ready_i = 1'b0;
    start_i = 1'b1; tick(); start_i = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    n = 0;
    while (!error_o && n < 200) begin tick(); n++; end
    checks++;
    if (n !== 22) begin errors++; $display("FAIL wdog_latency: got %0d expected %0d", n, 22); end
    tick();
    checks++;
    if (h_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL wdog_error_state: got h=%b busy=%b expected 0 1", h_valid_o, busy_o);
    end
    start_i = 1'b1; tick(); start_i = 1'b0; tick(); tick();
    checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b1 || w_valid_o !== 1'b0) begin
      errors++; $display("FAIL wdog_sticky: got err=%b busy=%b w=%b expected 1 1 0", error_o, busy_o, w_valid_o);
    end
    do_reset();
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL wdog_reset: got %b expected %b", error_o, 1'b0); end
`else
    n = 0;
    repeat (40) begin tick(); n++; end
    checks++;
    if (error_o !== 1'b0 || h_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL wdog_disabled: got err=%b h=%b busy=%b after %0d cycles expected 0 1 1",
                         error_o, h_valid_o, busy_o, n);
    end
    do_reset();
`endif
  endtask

  initial begin
    clear_trace();
    wcnt = 0; acnt = 0; hcnt = 0; ccnt = 0;
    test_reset();
    test_fast_path();
    test_basic_flow();
    test_ignored_inputs();
    test_reset_mid_op();
    test_back_to_back();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
